// File: rtl/a25_copro_initiator.sv
// Core-side master for the Amber 25 coprocessor transfer interface.
// Issues one MCR/MRC per request to the CP15 responder and returns one response.
module a25_copro_initiator #(
   parameter logic [3:0] COPRO_NUM = 4'd15
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_core_stall,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_write,
   input  logic [3:0]  i_req_num,
   input  logic [2:0]  i_req_opcode1,
   input  logic [2:0]  i_req_opcode2,
   input  logic [3:0]  i_req_crn,
   input  logic [3:0]  i_req_crm,
   input  logic [31:0] i_req_wdata,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [31:0] o_rsp_rdata,
   output logic        o_rsp_error,
   output logic [2:0]  o_copro_opcode1,
   output logic [2:0]  o_copro_opcode2,
   output logic [3:0]  o_copro_crn,
   output logic [3:0]  o_copro_crm,
   output logic [3:0]  o_copro_num,
   output logic [1:0]  o_copro_operation,
   output logic [31:0] o_copro_write_data,
   input  logic [31:0] i_copro_read_data
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      CAPTURE,
      RESP
   } state_t;

   localparam logic [1:0] OP_IDLE = 2'd0;
   localparam logic [1:0] OP_MRC  = 2'd1;
   localparam logic [1:0] OP_MCR  = 2'd2;

   state_t state;
   state_t state_next;
   logic   accept;
   logic   num_match;

   assign accept    = i_req_valid & o_req_ready;
   assign num_match = (i_req_num == COPRO_NUM);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // The ISSUE exit relies on the latched operation to tell a write from a read.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = num_match ? ISSUE : RESP;
            end
         end
         ISSUE: begin
            if (!i_core_stall) begin
               state_next = (o_copro_operation == OP_MCR) ? RESP : CAPTURE;
            end
         end
         CAPTURE: state_next = RESP;
         RESP: begin
            if (i_rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      o_req_ready = (state == IDLE);
      o_rsp_valid = (state == RESP);
   end

   // Bus fields stay latched after ISSUE so crn is still stable while read data is captured.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_copro_opcode1    <= 3'd0;
         o_copro_opcode2    <= 3'd0;
         o_copro_crn        <= 4'd0;
         o_copro_crm        <= 4'd0;
         o_copro_num        <= 4'd0;
         o_copro_operation  <= OP_IDLE;
         o_copro_write_data <= 32'd0;
         o_rsp_rdata        <= 32'd0;
         o_rsp_error        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  o_rsp_rdata <= 32'd0;
                  if (num_match) begin
                     o_rsp_error        <= 1'b0;
                     o_copro_opcode1    <= i_req_opcode1;
                     o_copro_opcode2    <= i_req_opcode2;
                     o_copro_crn        <= i_req_crn;
                     o_copro_crm        <= i_req_crm;
                     o_copro_num        <= i_req_num;
                     o_copro_write_data <= i_req_wdata;
                     o_copro_operation  <= i_req_write ? OP_MCR : OP_MRC;
                  end else begin
                     o_rsp_error <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (!i_core_stall) begin
                  o_copro_operation <= OP_IDLE;
               end
            end
            CAPTURE: begin
               o_rsp_rdata <= i_copro_read_data;
            end
            RESP: begin
               if (i_rsp_ready) begin
                  o_rsp_rdata <= 32'd0;
                  o_rsp_error <= 1'b0;
               end
            end
            default: begin
               o_copro_operation <= OP_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_a25_copro_initiator.sv
// Directed bench for a25_copro_initiator with a small CP15 responder model.
module tb_a25_copro_initiator;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_core_stall;
   logic        i_req_valid;
   logic        o_req_ready;
   logic        i_req_write;
   logic [3:0]  i_req_num;
   logic [2:0]  i_req_opcode1;
   logic [2:0]  i_req_opcode2;
   logic [3:0]  i_req_crn;
   logic [3:0]  i_req_crm;
   logic [31:0] i_req_wdata;
   logic        o_rsp_valid;
   logic        i_rsp_ready;
   logic [31:0] o_rsp_rdata;
   logic        o_rsp_error;
   logic [2:0]  o_copro_opcode1;
   logic [2:0]  o_copro_opcode2;
   logic [3:0]  o_copro_crn;
   logic [3:0]  o_copro_crm;
   logic [3:0]  o_copro_num;
   logic [1:0]  o_copro_operation;
   logic [31:0] o_copro_write_data;
   logic [31:0] i_copro_read_data;

   int testCount = 0;
   int failCount = 0;

   localparam logic [31:0] CP15_ID = 32'h41560300;

   logic [31:0] cpRegs [16] = '{default: 32'd0};
   int          writeCount = 0;

   a25_copro_initiator #(.COPRO_NUM(4'd15)) dut (
      .i_clk              (i_clk),
      .i_reset            (i_reset),
      .i_core_stall       (i_core_stall),
      .i_req_valid        (i_req_valid),
      .o_req_ready        (o_req_ready),
      .i_req_write        (i_req_write),
      .i_req_num          (i_req_num),
      .i_req_opcode1      (i_req_opcode1),
      .i_req_opcode2      (i_req_opcode2),
      .i_req_crn          (i_req_crn),
      .i_req_crm          (i_req_crm),
      .i_req_wdata        (i_req_wdata),
      .o_rsp_valid        (o_rsp_valid),
      .i_rsp_ready        (i_rsp_ready),
      .o_rsp_rdata        (o_rsp_rdata),
      .o_rsp_error        (o_rsp_error),
      .o_copro_opcode1    (o_copro_opcode1),
      .o_copro_opcode2    (o_copro_opcode2),
      .o_copro_crn        (o_copro_crn),
      .o_copro_crm        (o_copro_crm),
      .o_copro_num        (o_copro_num),
      .o_copro_operation  (o_copro_operation),
      .o_copro_write_data (o_copro_write_data),
      .i_copro_read_data  (i_copro_read_data)
   );

   always #5 i_clk = ~i_clk;

   // Responder: acts on any unstalled edge, read data registered for the current crn.
   always @(posedge i_clk) begin
      if (!i_core_stall) begin
         if (o_copro_operation == 2'd2) begin
            writeCount <= writeCount + 1;
            if (o_copro_crn != 4'd0) begin
               cpRegs[o_copro_crn] <= o_copro_write_data;
            end
         end
         i_copro_read_data <= (o_copro_crn == 4'd0) ? CP15_ID : cpRegs[o_copro_crn];
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input string tag, input logic wr, input logic [3:0] num,
                                input logic [3:0] crn, input logic [31:0] wdata,
                                input int stallCycles, input logic [31:0] expRdata);
      int n;
      int opCycles;
      int writesBefore;
      int expLat;
      logic isErr;
      logic busHeld;
      isErr        = (num != 4'd15);
      expLat       = isErr ? 1 : ((wr ? 2 : 3) + stallCycles);
      writesBefore = writeCount;
      checkOutput({tag, ".ready_idle"}, 32'(o_req_ready), 32'd1);
      i_req_valid   = 1'b1;
      i_req_write   = wr;
      i_req_num     = num;
      i_req_opcode1 = 3'd5;
      i_req_opcode2 = 3'd6;
      i_req_crn     = crn;
      i_req_crm     = 4'd9;
      i_req_wdata   = wdata;
      i_rsp_ready   = 1'b1;
      i_core_stall  = 1'b0;
      tick();
      i_req_valid = 1'b0;
      n        = 1;
      opCycles = 0;
      busHeld  = 1'b1;
      checkOutput({tag, ".ready_drop"}, 32'(o_req_ready), 32'd0);
      while (!o_rsp_valid && n < 60) begin
         if (o_copro_operation != 2'd0) begin
            opCycles++;
            if (o_copro_operation != (wr ? 2'd2 : 2'd1) || o_copro_crn != crn ||
                o_copro_num != num || o_copro_opcode1 != 3'd5 || o_copro_opcode2 != 3'd6 ||
                o_copro_crm != 4'd9 || o_copro_write_data != wdata) begin
               busHeld = 1'b0;
            end
         end
         i_core_stall = (n <= stallCycles);
         tick();
         n++;
      end
      i_core_stall = 1'b0;
      checkOutput({tag, ".latency"}, 32'(n), 32'(expLat));
      checkOutput({tag, ".rdata"}, o_rsp_rdata, expRdata);
      checkOutput({tag, ".error"}, 32'(o_rsp_error), 32'(isErr));
      checkOutput({tag, ".op_cycles"}, 32'(opCycles), isErr ? 32'd0 : 32'(stallCycles + 1));
      checkOutput({tag, ".bus_held"}, 32'(busHeld), 32'd1);
      checkOutput({tag, ".op_in_resp"}, 32'(o_copro_operation), 32'd0);
      checkOutput({tag, ".writes"}, 32'(writeCount - writesBefore), (wr && !isErr) ? 32'd1 : 32'd0);
      tick();
      checkOutput({tag, ".valid_clear"}, 32'(o_rsp_valid), 32'd0);
      checkOutput({tag, ".ready_back"}, 32'(o_req_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] cacheEnable;
      int writesBefore;
      i_reset       = 1'b1;
      i_core_stall  = 1'b0;
      i_req_valid   = 1'b0;
      i_req_write   = 1'b0;
      i_req_num     = 4'd0;
      i_req_opcode1 = 3'd0;
      i_req_opcode2 = 3'd0;
      i_req_crn     = 4'd0;
      i_req_crm     = 4'd0;
      i_req_wdata   = 32'd0;
      i_rsp_ready   = 1'b0;
      tick();
      tick();
      i_reset = 1'b0;
      tick();
      checkOutput("rst.ready", 32'(o_req_ready), 32'd1);
      checkOutput("rst.valid", 32'(o_rsp_valid), 32'd0);
      checkOutput("rst.op", 32'(o_copro_operation), 32'd0);
      checkOutput("rst.crn", 32'(o_copro_crn), 32'd0);
      checkOutput("rst.wdata", o_copro_write_data, 32'd0);

      applyStimulus("mcr_crn2", 1'b1, 4'd15, 4'd2, 32'h00000007, 0, 32'd0);
      cacheEnable = 32'(cpRegs[2][0]);
      checkOutput("mcr_crn2.cache_enable", cacheEnable, 32'd1);
      applyStimulus("mrc_crn2", 1'b0, 4'd15, 4'd2, 32'd0, 0, 32'h00000007);
      applyStimulus("mrc_crn0", 1'b0, 4'd15, 4'd0, 32'd0, 0, CP15_ID);
      applyStimulus("mrc_crn9", 1'b0, 4'd15, 4'd9, 32'd0, 0, 32'd0);
      applyStimulus("mcr_stall", 1'b1, 4'd15, 4'd3, 32'hA5A5A5A5, 5, 32'd0);
      applyStimulus("mrc_crn3", 1'b0, 4'd15, 4'd3, 32'd0, 0, 32'hA5A5A5A5);
      applyStimulus("bad_num", 1'b1, 4'd14, 4'd2, 32'hDEADBEEF, 0, 32'd0);
      applyStimulus("mrc_stall", 1'b0, 4'd15, 4'd2, 32'd0, 2, 32'h00000007);

      // Response backpressure with a second request already waiting.
      i_req_valid = 1'b1;
      i_req_write = 1'b0;
      i_req_num   = 4'd15;
      i_req_crn   = 4'd0;
      i_rsp_ready = 1'b0;
      tick();
      i_req_crn = 4'd2;
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         checkOutput("bp.valid_held", 32'(o_rsp_valid), 32'd1);
         checkOutput("bp.rdata_held", o_rsp_rdata, CP15_ID);
         checkOutput("bp.ready_low", 32'(o_req_ready), 32'd0);
         tick();
      end
      checkOutput("bp.valid_last", 32'(o_rsp_valid), 32'd1);
      i_rsp_ready = 1'b1;
      tick();
      checkOutput("bp.valid_clear", 32'(o_rsp_valid), 32'd0);
      checkOutput("bp.ready_back", 32'(o_req_ready), 32'd1);
      tick();
      i_req_valid = 1'b0;
      checkOutput("bp.second_accept", 32'(o_req_ready), 32'd0);
      checkOutput("bp.second_op", 32'(o_copro_operation), 32'd1);
      checkOutput("bp.second_crn", 32'(o_copro_crn), 32'd2);
      tick();
      tick();
      checkOutput("bp.second_valid", 32'(o_rsp_valid), 32'd1);
      checkOutput("bp.second_rdata", o_rsp_rdata, 32'h00000007);
      tick();
      checkOutput("bp.second_done", 32'(o_req_ready), 32'd1);

      // Reset while ISSUE is stalled drops the transfer.
      writesBefore = writeCount;
      i_req_valid  = 1'b1;
      i_req_write  = 1'b1;
      i_req_num    = 4'd15;
      i_req_crn    = 4'd3;
      i_req_wdata  = 32'h12345678;
      i_core_stall = 1'b1;
      tick();
      i_req_valid = 1'b0;
      checkOutput("rstmid.op_issue", 32'(o_copro_operation), 32'd2);
      tick();
      i_reset = 1'b1;
      tick();
      i_reset      = 1'b0;
      i_core_stall = 1'b0;
      checkOutput("rstmid.ready", 32'(o_req_ready), 32'd1);
      checkOutput("rstmid.valid", 32'(o_rsp_valid), 32'd0);
      checkOutput("rstmid.op", 32'(o_copro_operation), 32'd0);
      checkOutput("rstmid.crn", 32'(o_copro_crn), 32'd0);
      checkOutput("rstmid.num", 32'(o_copro_num), 32'd0);
      checkOutput("rstmid.wdata", o_copro_write_data, 32'd0);
      checkOutput("rstmid.error", 32'(o_rsp_error), 32'd0);
      checkOutput("rstmid.rdata", o_rsp_rdata, 32'd0);
      for (int i = 0; i < 4; i++) begin
         checkOutput("rstmid.no_rsp", 32'(o_rsp_valid), 32'd0);
         tick();
      end
      checkOutput("rstmid.no_write", 32'(writeCount - writesBefore), 32'd0);
      applyStimulus("post_rst_crn0", 1'b0, 4'd15, 4'd0, 32'd0, 0, CP15_ID);
      applyStimulus("post_rst_crn3", 1'b0, 4'd15, 4'd3, 32'd0, 0, 32'hA5A5A5A5);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/a25_copro_initiator.md
Name: a25_copro_initiator

Overview:
- Core-side master for the Amber 25 coprocessor transfer interface.
- Accepts MCR (write) and MRC (read) requests from the execute stage over a valid/ready handshake and drives the opcode1/opcode2/crn/crm/num/operation/write_data bus to the CP15 responder.
- Honours the global core stall, captures MRC read data and returns one response per request on a valid/ready response channel.
- Sits between execute-stage control and the CP15 register block.

Parameters:
- COPRO_NUM, 15: coprocessor number served. Requests with any other number complete immediately with an error and never reach the bus.

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  synchronous active-high reset
- i_core_stall  input  1  global stall; the responder ignores the bus while high
- i_req_valid  input  1  request valid
- o_req_ready  output  1  request accepted when valid & ready at posedge
- i_req_write  input  1  1 = MCR (write), 0 = MRC (read)
- i_req_num  input  4  coprocessor number
- i_req_opcode1  input  3  opcode1 field
- i_req_opcode2  input  3  opcode2 field
- i_req_crn  input  4  coprocessor register number
- i_req_crm  input  4  crm field
- i_req_wdata  input  32  MCR data
- o_rsp_valid  output  1  response valid
- i_rsp_ready  input  1  response consumed when valid & ready at posedge
- o_rsp_rdata  output  32  MRC data; 0 for MCR and error responses
- o_rsp_error  output  1  coprocessor number mismatch
- o_copro_opcode1  output  3  to responder
- o_copro_opcode2  output  3  to responder
- o_copro_crn  output  4  to responder
- o_copro_crm  output  4  to responder
- o_copro_num  output  4  to responder
- o_copro_operation  output  2  0 idle, 1 MRC, 2 MCR; value 3 is never driven
- o_copro_write_data  output  32  to responder
- i_copro_read_data  input  32  responder registered read data

Behaviour:
- Reset (synchronous): state IDLE; o_req_ready 1; o_rsp_valid 0; o_rsp_error 0; o_rsp_rdata 0; o_copro_operation 0; all other o_copro_* 0.
- The responder samples the bus on any posedge with i_core_stall low. It registers read data for the current crn on that same edge; the data is valid from the next cycle.
- IDLE:
  - o_req_ready = 1 (registered).
  - On accept with num != COPRO_NUM: go to RESP with error=1, rdata=0. The bus stays idle.
  - On accept otherwise: latch all fields onto o_copro_*, set operation to 2 (write) or 1 (read), go to ISSUE.
  - o_req_ready drops to 0 on the accept edge.
- ISSUE:
  - Hold all o_copro_* while i_core_stall = 1. The stall count is unbounded.
  - On the first posedge with stall low:
    - write: operation to 0, go to RESP with error=0, rdata=0.
    - read: operation to 0, keep crn held, go to CAPTURE.
- CAPTURE:
  - One cycle. o_rsp_rdata <= i_copro_read_data regardless of stall; the value is stable because crn is held. Go to RESP.
- RESP:
  - o_rsp_valid = 1 with data/error held until i_rsp_ready at a posedge.
  - Then valid 0, ready 1, go to IDLE.
  - The response channel ignores i_core_stall.
- Latency, no stall, i_rsp_ready high:
  - error: response valid 1 cycle after the accept edge.
  - MCR: 2 cycles.
  - MRC: 3 cycles.
  - Next request accepted 1 cycle after the response handshake. Exactly one outstanding transfer.
- o_copro_operation is nonzero only in ISSUE. It never stays nonzero across a non-stalled edge, so each request causes exactly one responder write or read and at most one flush pulse.
- i_req_* and i_rsp_ready are don't-care outside the relevant handshake; i_req_* is sampled only on accept.
- Reset mid-operation: the transfer is dropped and no response is produced. If reset coincides with a non-stalled ISSUE edge, the responder may still commit the write; this is accepted.

Test Plan:
- MCR num 15, crn 2, wdata 0x00000007, no stall -> operation=2 for exactly one cycle; response at +2 with rdata 0, error 0; responder cache_enable=1. Then MRC crn 2 -> rdata 0x00000007 at +3.
- MRC crn 0 -> rdata 0x41560300. MRC crn 9 -> rdata 0x00000000.
- MCR crn 3, wdata 0xA5A5A5A5 with i_core_stall held high 5 cycles during ISSUE -> bus fields constant for 6 cycles, single responder write; MRC crn 3 -> 0xA5A5A5A5.
- Request num 14 -> response at +1 with error 1, rdata 0; o_copro_operation stays 0 throughout.
- Back-to-back requests with i_rsp_ready low for 4 cycles -> o_rsp_valid and data held, o_req_ready 0; second request accepted 1 cycle after the handshake.
- i_reset pulsed while ISSUE is stalled -> next cycle all outputs at reset values, no response; subsequent MRC crn 0 returns 0x41560300 normally.
